// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: default sizes and the byte type used by the
// receiver and the receive FIFO.
package uart_pkg;

    localparam int unsigned DataBitsDefault = 8;
    localparam int unsigned DepthDefault    = 16;

    typedef logic [DataBitsDefault-1:0] rxByte_t;

endpackage

// File: rtl/rx_byte_fifo_if.sv
// Receive FIFO bus: UART write strobe, show-ahead read handshake and status flags.
interface rx_byte_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DataBitsDefault,
    parameter int unsigned DEPTH     = DepthDefault
);

    logic                       RxReady;
    logic [DATA_BITS-1:0]       RxData;
    logic                       RdValid;
    logic [DATA_BITS-1:0]       RdData;
    logic                       RdReady;
    logic [$clog2(DEPTH):0]     Count;
    logic                       Full;
    logic                       Empty;
    logic                       Overflow;
    logic                       OverflowClear;

    // Driven by the receiver/consumer side.
    modport master (
        output RxReady, RxData, RdReady, OverflowClear,
        input  RdValid, RdData, Count, Full, Empty, Overflow
    );

    // Implemented by the FIFO.
    modport slave (
        input  RxReady, RxData, RdReady, OverflowClear,
        output RdValid, RdData, Count, Full, Empty, Overflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Reset-cleared storage array: one synchronous write port, one asynchronous read port.
module fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DataBitsDefault,
    parameter int unsigned DEPTH     = DepthDefault
) (
    input  logic                        Clock,
    input  logic                        ResetN,
    input  logic                        WrEn,
    input  logic [$clog2(DEPTH)-1:0]    WrAddr,
    input  logic [DATA_BITS-1:0]        WrData,
    input  logic [$clog2(DEPTH)-1:0]    RdAddr,
    output logic [DATA_BITS-1:0]        RdData
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
    end

    assign RdData = mem[RdAddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// UART receive byte FIFO: show-ahead read, Count-based occupancy, sticky overflow on drop.
module rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DataBitsDefault,
    parameter int unsigned DEPTH     = DepthDefault
) (
    input  logic            Clock,
    input  logic            ResetN,
    rx_byte_fifo_if.slave   bus
);

    localparam int unsigned PtrBits = $clog2(DEPTH);
    localparam int unsigned CntBits = PtrBits + 1;

    logic [PtrBits-1:0] wrPtrQ, wrPtrD;
    logic [PtrBits-1:0] rdPtrQ, rdPtrD;
    logic [CntBits-1:0] countQ, countD;
    logic               overflowQ, overflowD;

    logic full, empty, pop, wrAccept, drop;

    assign full  = (countQ == CntBits'(DEPTH));
    assign empty = (countQ == '0);

    // A pop frees the slot in the same cycle, so a write into a full FIFO is still accepted.
    assign pop      = !empty && bus.RdReady;
    assign wrAccept = bus.RxReady && (!full || pop);
    assign drop     = bus.RxReady && full && !pop;

    always_comb begin
        wrPtrD    = wrPtrQ;
        rdPtrD    = rdPtrQ;
        countD    = countQ;
        overflowD = overflowQ;

        if (wrAccept) begin
            wrPtrD = wrPtrQ + PtrBits'(1);
        end
        if (pop) begin
            rdPtrD = rdPtrQ + PtrBits'(1);
        end

        unique case ({wrAccept, pop})
            2'b10:   countD = countQ + CntBits'(1);
            2'b01:   countD = countQ - CntBits'(1);
            default: countD = countQ;
        endcase

        // A drop on the clearing edge wins so no loss goes unreported.
        if (drop) begin
            overflowD = 1'b1;
        end else if (bus.OverflowClear) begin
            overflowD = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            countQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            wrPtrQ    <= wrPtrD;
            rdPtrQ    <= rdPtrD;
            countQ    <= countD;
            overflowQ <= overflowD;
        end
    end

    fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) uMem (
        .Clock  (Clock),
        .ResetN (ResetN),
        .WrEn   (wrAccept),
        .WrAddr (wrPtrQ),
        .WrData (bus.RxData),
        .RdAddr (rdPtrQ),
        .RdData (bus.RdData)
    );

    assign bus.RdValid  = !empty;
    assign bus.Count    = countQ;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
    assign bus.Overflow = overflowQ;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed-vector bench for rx_byte_fifo: table of per-edge stimulus and expected outputs,
// plus a hand-written asynchronous reset sequence.
module tb_rx_byte_fifo;
    import uart_pkg::*;

    localparam int unsigned DataBits = 8;
    localparam int unsigned Depth    = 16;

    typedef struct {
        string   name;
        bit      rxReady;
        rxByte_t rxData;
        bit      rdReady;
        bit      ovClr;
        int      expCount;
        rxByte_t expHead;
        bit      chkHead;
        bit      expOvf;
    } vec_t;

    logic Clock;
    logic ResetN;
    vec_t vecs[$];
    int   vectors;
    int   miscompares;

    rx_byte_fifo_if #(.DATA_BITS(DataBits), .DEPTH(Depth)) bus ();

    rx_byte_fifo #(
        .DATA_BITS (DataBits),
        .DEPTH     (Depth)
    ) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    task automatic add(input string nm, input bit wr, input int d, input bit rd, input bit clr,
                       input int cnt, input int head, input bit chk, input bit ovf);
        vec_t v;
        v.name     = nm;
        v.rxReady  = wr;
        v.rxData   = rxByte_t'(d);
        v.rdReady  = rd;
        v.ovClr    = clr;
        v.expCount = cnt;
        v.expHead  = rxByte_t'(head);
        v.chkHead  = chk;
        v.expOvf   = ovf;
        vecs.push_back(v);
    endtask

    // Flags follow from the expected count; head data checked only when chk is set.
    task automatic checkNow(input string nm, input int cnt, input rxByte_t head, input bit chk,
                            input bit ovf);
        bit ok;
        bit eValid;
        bit eFull;
        bit eEmpty;
        eValid = (cnt != 0);
        eFull  = (cnt == Depth);
        eEmpty = (cnt == 0);
        ok = (int'(bus.Count) == cnt) && (bus.RdValid == eValid) && (bus.Full == eFull)
            && (bus.Empty == eEmpty) && (bus.Overflow == ovf) && (!chk || bus.RdData == head);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got cnt=%0d valid=%0b full=%0b empty=%0b ovf=%0b data=%02h; want cnt=%0d valid=%0b full=%0b empty=%0b ovf=%0b data=%02h(chk=%0b)",
                     nm, bus.Count, bus.RdValid, bus.Full, bus.Empty, bus.Overflow, bus.RdData,
                     cnt, eValid, eFull, eEmpty, ovf, head, chk);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.RxReady       = v.rxReady;
        bus.RxData        = v.rxData;
        bus.RdReady       = v.rdReady;
        bus.OverflowClear = v.ovClr;
        @(posedge Clock);
        #1;
        checkNow(v.name, v.expCount, v.expHead, v.chkHead, v.expOvf);
    endtask

    task automatic idle();
        bus.RxReady       = 1'b0;
        bus.RxData        = '0;
        bus.RdReady       = 1'b0;
        bus.OverflowClear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion within budget");
        $fatal(1);
    end

    initial begin
        int b;
        vectors     = 0;
        miscompares = 0;

        // Single byte round trip; stale read data after empty is cleared entry 1.
        add("wrA5", 1, 'hA5, 0, 0, 1, 'hA5, 1, 0);
        add("popA5", 0, 0, 1, 0, 0, 'h00, 1, 0);
        add("rdWhileEmpty", 0, 0, 1, 0, 0, 'h00, 1, 0);
        // Fill with strobe held high: head stays 0x00.
        for (int i = 0; i < 16; i++) add("fill", 1, i, 0, 0, i + 1, 'h00, 1, 0);
        add("ovf55", 1, 'h55, 0, 0, 16, 'h00, 1, 1);
        add("ovfHold", 0, 0, 0, 0, 16, 'h00, 1, 1);
        add("ovfClr", 0, 0, 0, 1, 16, 'h00, 1, 0);
        add("ovfClrAndDrop", 1, 'h66, 0, 1, 16, 'h00, 1, 1);
        add("ovfClr2", 0, 0, 0, 1, 16, 'h00, 1, 0);
        // Write into full FIFO with a pop: 0x77 goes to the back.
        add("wr77Pop", 1, 'h77, 1, 0, 16, 'h01, 1, 0);
        for (int k = 1; k <= 15; k++) add("drain", 0, 0, 1, 0, 16 - k, (k < 15) ? k + 1 : 'h77, 1, 0);
        add("drainLast", 0, 0, 1, 0, 0, 0, 0, 0);
        add("wrB0", 1, 'hB0, 0, 0, 1, 'hB0, 1, 0);
        add("wrPopSame", 1, 'hB1, 1, 0, 1, 'hB1, 1, 0);
        add("popB1", 0, 0, 1, 0, 0, 0, 0, 0);
        // Alternating write/pop across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            b = (i * 7 + 3) & 'hFF;
            add("altWr", 1, b, 0, 0, 1, b, 1, 0);
            add("altPop", 0, 0, 1, 0, 0, 0, 0, 0);
        end

        idle();
        ResetN = 1'b0;
        #25;
        checkNow("resetState", 0, 'h00, 1, 0);
        @(negedge Clock);
        ResetN = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset mid-cycle with bytes stored and overflow set.
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v.name = "store5"; v.rxReady = 1; v.rxData = rxByte_t'(8'hC0 + i);
            v.rdReady = 0; v.ovClr = 0; v.expCount = i + 1; v.expHead = 8'hC0;
            v.chkHead = 1; v.expOvf = 0;
            apply(v);
        end
        idle();
        @(negedge Clock);
        #3;
        ResetN = 1'b0;
        #1;
        checkNow("midReset", 0, 'h00, 1, 0);
        @(negedge Clock);
        ResetN = 1'b1;
        begin
            vec_t v;
            v.name = "postResetWr"; v.rxReady = 1; v.rxData = 8'h3C; v.rdReady = 0;
            v.ovClr = 0; v.expCount = 1; v.expHead = 8'h3C; v.chkHead = 1; v.expOvf = 0;
            apply(v);
            v.name = "postResetPop"; v.rxReady = 0; v.rxData = 8'h00; v.rdReady = 1;
            v.expCount = 0; v.expHead = 8'h00; v.chkHead = 1;
            apply(v);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, width of each stored byte.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, minimum 2.
REQ-003 Clock  input  1  system clock (50 MHz), all logic on rising edge.
REQ-004 ResetN  input  1  reset, asynchronous, active-low.
REQ-005 RxReady  input  1  one-cycle write strobe from UART receiver.
REQ-006 RxData  input  DATA_BITS  byte from UART receiver, valid when RxReady=1.
REQ-007 RdValid  output  1  head entry available (equals not Empty).
REQ-008 RdData  output  DATA_BITS  head entry (show-ahead), valid when RdValid=1.
REQ-009 RdReady  input  1  consumer accepts head; pop occurs when RdValid and RdReady are both 1.
REQ-010 Count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-011 Full  output  1  Count==DEPTH.
REQ-012 Empty  output  1  Count==0.
REQ-013 Overflow  output  1  sticky flag, byte dropped.
REQ-014 OverflowClear  input  1  synchronous clear of Overflow.

Function
REQ-015 Write accepted on a rising edge with RxReady=1 when not Full, or when Full with a pop in the same cycle.
REQ-016 Accepted byte stored at write pointer; write pointer increments by 1 modulo DEPTH.
REQ-017 Pop increments read pointer by 1 modulo DEPTH; RdReady with RdValid=0 has no effect.
REQ-018 Count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop or on neither.
REQ-019 Write-to-read latency one cycle: byte written at edge N appears on RdData/RdValid after edge N; no same-cycle bypass when Empty.
REQ-020 RdData SHALL be the entry at read pointer, combinationally; no register stage between memory and RdData.
REQ-021 RdData while Empty SHALL be the stale entry at read pointer; consumer must ignore it.
REQ-022 RxReady=1 while Full with no pop: byte discarded, memory/pointers/Count unchanged, Overflow set at that edge.
REQ-023 Overflow held until an edge with OverflowClear=1; if clear and a new drop occur at the same edge, Overflow SHALL be 1.
REQ-024 Full, Empty, RdValid derived combinationally from Count.
REQ-025 Pointers log2(DEPTH) bits each, wrap naturally; no wrap-bit comparison, Count is the sole occupancy source.
REQ-026 RxReady held high multiple cycles SHALL write once per cycle (no edge detection).

Reset
REQ-027 ResetN=0 asynchronously clears pointers, Count, Overflow and all memory entries to 0.
REQ-028 After reset: RdValid=0, RdData=0, Count=0, Full=0, Empty=1, Overflow=0.
REQ-029 Reset mid-operation discards all stored bytes; first write after release lands in entry 0.

Structure
REQ-030 Shared package uart_pkg SHALL hold DATA_BITS default, DEPTH default and a byte typedef shared with the receiver.
REQ-031 Storage SHALL be a sub-module fifo_mem (DEPTH x DATA_BITS, reset-cleared, one write port, one async read port); pointer/count logic in rx_byte_fifo.

Verification
REQ-032 Reset, write 0xA5 one strobe -> next cycle RdValid=1, RdData=0xA5, Count=1; pop -> Empty=1, Count=0.
REQ-033 Write 0x00..0x0F (16 strobes), RdReady=0 -> Full=1, Count=16; drain -> 0x00..0x0F in order, Empty=1.
REQ-034 Full, write 0x55 with RdReady=0 -> Overflow=1, Count=16, head still 0x00; OverflowClear -> Overflow=0.
REQ-035 Full, write 0x77 with pop same cycle -> Count=16, Overflow=0, 0x77 read last after 15 others.
REQ-036 Alternate write/pop for 40 bytes across pointer wrap -> Count never exceeds 1, data order exact.
REQ-037 Store 5 bytes, assert ResetN=0 mid-cycle -> outputs immediately at reset values; next write read back first.
